// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================
// fir_pkg : shared types and helpers for fir_parallel_cfg
// Rev 1.0
// ============================================================
package fir_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOAD = 1'b1
  } load_state_e;

  localparam int SAT_W = 64;

  function automatic int acc_w(input int nb, input int nt);
    return 2 * nb + $clog2(nt + 1);
  endfunction

  // Drops the Q1.(nb-1) scale with floor, then clamps to the nb-bit signed range.
  function automatic logic signed [SAT_W-1:0] sat_shift(input logic signed [SAT_W-1:0] acc,
                                                       input int nb);
    logic signed [SAT_W-1:0] sh;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sh = acc >>> (nb - 1);
    hi = (64'sd1 <<< (nb - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (nb - 1));
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

  function automatic int lane_lo(input int j, input int nb);
    return j * nb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_parallel_cfg_lane.sv
`default_nettype none
// ============================================================
// fir_lane : one output lane, NT+1 multiplies plus adder tree
// Rev 1.0
// ============================================================
module fir_lane
  import fir_pkg::*;
#(
  parameter int NB   = 8,
  parameter int NT   = 10,
  parameter int PIPE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [(NT+1)*NB-1:0] taps,
  input  logic [(NT+1)*NB-1:0] coefs,
  output logic [NB-1:0]        y
);

  localparam int PW = 2 * NB;
  localparam int AW = acc_w(NB, NT);

  logic signed [PW-1:0]    prod_d   [NT+1];
  logic signed [PW-1:0]    prod_use [NT+1];
  logic signed [AW-1:0]    acc;
  logic signed [SAT_W-1:0] sat;

  always_comb begin : p_mul
    for (int i = 0; i <= NT; i++) begin
      prod_d[i] = PW'($signed(taps[i*NB +: NB])) * PW'($signed(coefs[i*NB +: NB]));
    end
  end

  if (PIPE != 0) begin : g_preg
    logic signed [PW-1:0] prod_q [NT+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        prod_q <= '{default: '0};
      end else begin
        prod_q <= prod_d;
      end
    end

    always_comb prod_use = prod_q;
  end else begin : g_nopreg
    logic unused_ok;
    assign unused_ok = clk ^ rst;
    always_comb prod_use = prod_d;
  end

  always_comb begin : p_acc
    acc = '0;
    for (int i = 0; i <= NT; i++) begin
      acc = acc + AW'(prod_use[i]);
    end
    sat = sat_shift(SAT_W'(acc), NB);
  end

  assign y = sat[NB-1:0];

endmodule
`default_nettype wire

// File: rtl/fir_parallel_cfg.sv
`default_nettype none
// ============================================================
// fir_parallel_cfg : L-way unfolded FIR, double-buffered coefs
// Rev 1.0
// ============================================================
module fir_parallel_cfg
  import fir_pkg::*;
#(
  parameter int NB   = 8,
  parameter int NT   = 10,
  parameter int L    = 3,
  parameter int PIPE = 0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [L*NB-1:0] DIN,
  input  logic          VIN,
  input  logic [NB-1:0] COEF_IN,
  input  logic          COEF_LD,
  output logic          COEF_DONE,
  output logic [L*NB-1:0] DOUT,
  output logic          VOUT
);

  localparam int WN    = NT + L;
  localparam int CNT_W = (NT > 0) ? $clog2(NT + 1) : 1;

  // Sample window: [0..NT-1] is the delay line, [NT..NT+L-1] the block just captured.
  logic [NB-1:0]        win_q    [WN];
  logic [NB-1:0]        win_d    [WN];
  logic [NB-1:0]        shadow_q [NT+1];
  logic [NB-1:0]        shadow_d [NT+1];
  logic [NB-1:0]        active_q [NT+1];
  logic [NB-1:0]        active_d [NT+1];
  logic [NB-1:0]        coef_s1_q [NT+1];
  logic [NB-1:0]        coef_s1_d [NT+1];
  load_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 swap_q, swap_d;
  logic                 done_q, done_d;
  logic                 v1_q, v1_d;
  logic                 vp_q, vp_d;
  logic                 vout_q, vout_d;
  logic [L*NB-1:0]      dout_q, dout_d;
  logic [NB-1:0]        lane_y [L];
  logic [(NT+1)*NB-1:0] coef_flat;
  logic                 v_last;

  assign v_last = (PIPE != 0) ? vp_q : v1_q;

  always_comb begin : p_next
    win_d     = win_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    coef_s1_d = coef_s1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    swap_d    = 1'b0;
    done_d    = swap_q;
    v1_d      = VIN;
    vp_d      = v1_q;
    vout_d    = v_last;
    dout_d    = dout_q;

    // Coefficients travel with the captured block, so a swap never splits one.
    if (VIN) begin
      for (int m = 0; m < NT; m++) win_d[m] = win_q[m + L];
      for (int j = 0; j < L; j++) win_d[NT + j] = DIN[lane_lo(j, NB) +: NB];
      coef_s1_d = active_q;
    end

    if (swap_q) active_d = shadow_q;

    case (state_q)
      IDLE: begin
        if (COEF_LD) begin
          shadow_d[NT] = COEF_IN;
          if (NT == 0) begin
            swap_d = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      LOAD: begin
        if (COEF_LD) begin
          for (int i = 0; i <= NT; i++) begin
            if (CNT_W'(NT - i) == cnt_q) shadow_d[i] = COEF_IN;
          end
          if (cnt_q == CNT_W'(NT)) begin
            state_d = IDLE;
            cnt_d   = '0;
            swap_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (v_last) begin
      for (int j = 0; j < L; j++) dout_d[j*NB +: NB] = lane_y[j];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      win_q     <= '{default: '0};
      shadow_q  <= '{default: '0};
      active_q  <= '{default: '0};
      coef_s1_q <= '{default: '0};
      state_q   <= IDLE;
      cnt_q     <= '0;
      swap_q    <= 1'b0;
      done_q    <= 1'b0;
      v1_q      <= 1'b0;
      vp_q      <= 1'b0;
      vout_q    <= 1'b0;
      dout_q    <= '0;
    end else begin
      win_q     <= win_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      coef_s1_q <= coef_s1_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      swap_q    <= swap_d;
      done_q    <= done_d;
      v1_q      <= v1_d;
      vp_q      <= vp_d;
      vout_q    <= vout_d;
      dout_q    <= dout_d;
    end
  end

  always_comb begin : p_coef_flat
    for (int i = 0; i <= NT; i++) coef_flat[i*NB +: NB] = coef_s1_q[i];
  end

  for (genvar j = 0; j < L; j++) begin : g_lane
    logic [(NT+1)*NB-1:0] taps;

    always_comb begin
      for (int i = 0; i <= NT; i++) taps[i*NB +: NB] = win_q[NT + j - i];
    end

    fir_lane #(
      .NB  (NB),
      .NT  (NT),
      .PIPE(PIPE)
    ) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .taps (taps),
      .coefs(coef_flat),
      .y    (lane_y[j])
    );
  end

  assign COEF_DONE = done_q;
  assign DOUT      = dout_q;
  assign VOUT      = vout_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_parallel_cfg.sv
`default_nettype none
// ============================================================
// tb_fir_parallel_cfg : checks PIPE=0 and PIPE=1 instances side by side
// Rev 1.0
// ============================================================
module tb_fir_parallel_cfg;

  localparam int NB   = 8;
  localparam int NT   = 10;
  localparam int L    = 3;
  localparam int DW   = L * NB;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          vin;
  logic          coef_ld;
  logic [NB-1:0] coef_in;
  logic [DW-1:0] din;
  logic          done0, done1, vout0, vout1;
  logic [DW-1:0] dout0, dout1;

  always #5 clk = ~clk;

  fir_parallel_cfg #(.NB(NB), .NT(NT), .L(L), .PIPE(0)) dut0 (
    .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .COEF_IN(coef_in), .COEF_LD(coef_ld),
    .COEF_DONE(done0), .DOUT(dout0), .VOUT(vout0)
  );

  fir_parallel_cfg #(.NB(NB), .NT(NT), .L(L), .PIPE(1)) dut1 (
    .CLK(clk), .RST(rst), .DIN(din), .VIN(vin), .COEF_IN(coef_in), .COEF_LD(coef_ld),
    .COEF_DONE(done1), .DOUT(dout1), .VOUT(vout1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: full sample history since reset and the two banks.
  int c = 0;
  bit capv [MAXC];
  int capy [MAXC][L];
  int held0 [L];
  int held1 [L];
  bit ev0, ev1, edone;
  int xs [$];
  int bank [NT+1];
  int shadow [NT+1];
  int wcnt = 0;
  int swap_at = -1;
  int done_cnt = 0;
  int obs0 [$];
  int obs1 [$];

  int imp_b [NT+1] = '{-1, -2, -4, 8, 35, 50, 35, 8, -4, -2, -1};
  int imp_y [15]   = '{-1, -2, -4, 7, 34, 49, 34, 7, -4, -2, -1, 0, 0, 0, 0};
  int sat_b [NT+1] = '{default: 127};
  int half_b [NT+1] = '{64, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int rb [NT+1];

  function automatic int ref_y(input int n);
    int acc = 0;
    int y;
    for (int i = 0; i <= NT; i++) begin
      if (n - i >= 0) acc += bank[i] * xs[n - i];
    end
    y = acc >>> (NB - 1);
    if (y > (1 <<< (NB - 1)) - 1) y = (1 <<< (NB - 1)) - 1;
    else if (y < -(1 <<< (NB - 1))) y = -(1 <<< (NB - 1));
    return y;
  endfunction

  function automatic logic [DW-1:0] pack(input int v [L]);
    logic [DW-1:0] r;
    r = '0;
    for (int j = 0; j < L; j++) r[j*NB +: NB] = v[j][NB-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom());
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, c, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    c++;
    if (c >= MAXC - 1) begin
      $display("FAIL cycle_budget: observed %0d edges, limit %0d", c, MAXC - 1);
      $fatal(1, "cycle budget exhausted");
    end
    if (rst) begin
      capv[c] = 1'b0;
      capv[c-1] = 1'b0;
      xs.delete();
      bank = '{default: 0};
      shadow = '{default: 0};
      wcnt = 0;
      swap_at = -1;
      edone = 1'b0;
      ev0 = 1'b0;
      ev1 = 1'b0;
      held0 = '{default: 0};
      held1 = '{default: 0};
    end else begin
      capv[c] = vin;
      if (vin) begin
        for (int j = 0; j < L; j++) xs.push_back(int'($signed(din[j*NB +: NB])));
        for (int j = 0; j < L; j++) capy[c][j] = ref_y(xs.size() - L + j);
      end
      edone = (c == swap_at);
      if (edone) bank = shadow;
      if (coef_ld) begin
        shadow[NT - wcnt] = int'($signed(coef_in));
        wcnt++;
        if (wcnt == NT + 1) begin
          wcnt = 0;
          swap_at = c + 1;
        end
      end
      ev0 = capv[c-1];
      if (ev0) for (int j = 0; j < L; j++) held0[j] = capy[c-1][j];
      ev1 = (c >= 2) && capv[c-2];
      if (ev1) for (int j = 0; j < L; j++) held1[j] = capy[c-2][j];
    end
    #1;
    check("vout_p0", 32'(vout0), 32'(ev0));
    check("vout_p1", 32'(vout1), 32'(ev1));
    check("dout_p0", 32'(dout0), 32'(pack(held0)));
    check("dout_p1", 32'(dout1), 32'(pack(held1)));
    check("done_p0", 32'(done0), 32'(edone));
    check("done_p1", 32'(done1), 32'(edone));
    if (done0) done_cnt++;
    if (vout0) for (int j = 0; j < L; j++) obs0.push_back(int'($signed(dout0[j*NB +: NB])));
    if (vout1) for (int j = 0; j < L; j++) obs1.push_back(int'($signed(dout1[j*NB +: NB])));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      rst = 1'b0; vin = 1'b0; coef_ld = 1'b0; din = rnd(); coef_in = NB'($urandom());
      tick();
    end
  endtask

  task automatic load_bank(input int b [NT+1], input int pause_at, input bit stream);
    for (int k = 0; k <= NT; k++) begin
      rst = 1'b0; coef_ld = 1'b1; coef_in = NB'(b[NT - k]); vin = stream; din = rnd();
      tick();
      if (k == pause_at) begin
        for (int p = 0; p < 3; p++) begin
          coef_ld = 1'b0; vin = stream; din = rnd();
          tick();
        end
      end
    end
    coef_ld = 1'b0;
  endtask

  task automatic check_impulse(input string tag);
    int o;
    check({tag, "_len_p0"}, 32'(obs0.size()), 32'(15));
    check({tag, "_len_p1"}, 32'(obs1.size()), 32'(15));
    for (int i = 0; i < 15; i++) begin
      o = (i < obs0.size()) ? obs0[i] : 9999;
      check({tag, "_p0"}, 32'(o), 32'(imp_y[i]));
      o = (i < obs1.size()) ? obs1[i] : 9999;
      check({tag, "_p1"}, 32'(o), 32'(imp_y[i]));
    end
  endtask

  task automatic send_block(input logic [DW-1:0] blk);
    rst = 1'b0; vin = 1'b1; coef_ld = 1'b0; din = blk;
    tick();
  endtask

  initial begin
    int d0;
    int last;
    rst = 1'b1; vin = 1'b1; coef_ld = 1'b1; din = rnd(); coef_in = NB'($urandom());

    // Reset dominates VIN and COEF_LD.
    tick();
    din = rnd(); coef_in = NB'($urandom());
    tick();
    send_block(rnd());
    idle(3);

    // Impulse response, both pipeline depths.
    rst = 1'b1; tick();
    load_bank(imp_b, -1, 1'b0);
    idle(2);
    obs0.delete(); obs1.delete();
    send_block(24'h00007F);
    for (int b = 0; b < 4; b++) send_block(24'h000000);
    idle(3);
    check_impulse("impulse");

    // Same impulse with random gaps and junk on DIN during gaps.
    obs0.delete(); obs1.delete();
    for (int b = 0; b < 5; b++) begin
      repeat ($urandom_range(0, 3)) begin
        rst = 1'b0; vin = 1'b0; din = rnd();
        tick();
      end
      send_block((b == 0) ? 24'h00007F : 24'h000000);
    end
    idle(3);
    check_impulse("gaps");

    // Saturation at both rails.
    rst = 1'b1; tick();
    load_bank(sat_b, -1, 1'b0);
    idle(2);
    for (int b = 0; b < 6; b++) send_block(24'h7F7F7F);
    idle(3);
    last = (obs0.size() > 0) ? obs0[$] : 9999;
    check("sat_hi_p0", 32'(last), 32'(127));
    last = (obs1.size() > 0) ? obs1[$] : 9999;
    check("sat_hi_p1", 32'(last), 32'(127));
    for (int b = 0; b < 6; b++) send_block(24'h808080);
    idle(3);
    last = (obs0.size() > 0) ? obs0[$] : 9999;
    check("sat_lo_p0", 32'(last), 32'(-128));
    last = (obs1.size() > 0) ? obs1[$] : 9999;
    check("sat_lo_p1", 32'(last), 32'(-128));

    // In-stream reload with a pause; exactly one COEF_DONE pulse.
    d0 = done_cnt;
    load_bank(half_b, 4, 1'b1);
    for (int k = 0; k < 3; k++) send_block(rnd());
    check("reload_done_count", 32'(done_cnt - d0), 32'(1));
    send_block(24'hFDFDFD);
    idle(3);
    for (int k = 1; k <= 3; k++) begin
      last = (obs0.size() >= k) ? obs0[obs0.size() - k] : 9999;
      check("half_p0", 32'(last), 32'(-2));
      last = (obs1.size() >= k) ? obs1[obs1.size() - k] : 9999;
      check("half_p1", 32'(last), 32'(-2));
    end

    // Reset partway through a load while streaming, then a full fresh load.
    for (int i = 0; i <= NT; i++) rb[i] = int'($urandom_range(0, 255)) - 128;
    for (int k = 0; k < 5; k++) begin
      rst = 1'b0; coef_ld = 1'b1; coef_in = NB'(rb[NT - k]); vin = 1'b1; din = rnd();
      tick();
    end
    rst = 1'b1; vin = 1'b1; coef_ld = 1'b1; din = rnd();
    tick();
    send_block(rnd());
    send_block(rnd());
    idle(2);
    last = (obs0.size() > 0) ? obs0[$] : 9999;
    check("zero_bank_p0", 32'(last), 32'(0));
    load_bank(rb, 7, 1'b1);
    idle(2);

    // Long random run: random VIN, data, coefficient traffic and one reset.
    for (int i = 0; i < 400; i++) begin
      rst     = (i == 200);
      vin     = ($urandom_range(0, 3) != 0);
      din     = rnd();
      coef_ld = ($urandom_range(0, 3) == 0);
      coef_in = NB'($urandom());
      tick();
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_parallel_cfg.md
Name: fir_parallel_cfg

Overview:
- Next-generation L-way parallel (unfolded) FIR filter: L samples per clock, L outputs per clock.
- Generalises the fixed 3-lane, 11-tap, 8-bit filter_top in lane count, order, width and pipeline depth.
- Adds a serial, double-buffered coefficient load with in-stream reload, and saturating outputs.
- Sits between the sample source and the result sink with valid-only (non-stalling) flow control.

Parameters:
NB, 8, sample/coefficient/output width, signed two's complement, Q1.(NB-1)
NT, 10, filter order; NT+1 taps
L, 3, parallel lanes (1..NT+1)
PIPE, 0, 1 inserts a product register between input stage and adder tree

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
DIN  in  L*NB  lane j at bits [(j+1)*NB-1 : j*NB]; lane 0 = oldest sample of block
VIN  in  1  DIN valid this cycle
COEF_IN  in  NB  serial coefficient word
COEF_LD  in  1  COEF_IN valid this cycle
COEF_DONE  out  1  one-cycle pulse: new bank active
DOUT  out  L*NB  lane j = y[L*k+j]
VOUT  out  1  DOUT valid

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high.
- Reset (RST=1 at an edge): delay line, both coefficient banks, load counter, pipeline valids, DOUT, VOUT and COEF_DONE all cleared to 0. RST dominates VIN/COEF_LD in the same cycle.
- Function: y[n] = sat( floor( sum_{i=0..NT} b_i*x[n-i] / 2^(NB-1) ) ).
  - Full-precision accumulator: 2*NB + ceil(log2(NT+1)) bits.
  - Divide is an arithmetic right shift (floor, no rounding).
  - Saturate to [-2^(NB-1), 2^(NB-1)-1].
- Delay line:
  - Holds the last NT samples; advances by L samples only on edges with VIN=1.
  - VIN=0 leaves it frozen, so the output sequence is independent of VIN gaps.
- Pipeline:
  - Stage 1: input register, captures DIN and updates the delay line.
  - Optional product register (PIPE=1).
  - Output register for DOUT.
  - A valid bit travels with the data. VOUT=1 exactly 1+PIPE cycles after each edge that samples VIN=1.
  - DOUT holds its last value when VOUT=0.
- Coefficient load, FSM IDLE / LOAD:
  - IDLE -> LOAD on the first COEF_LD=1; that word is written to the shadow bank at index NT.
  - Each subsequent COEF_LD=1 word goes to the next lower index, so the order is b_NT first, b_0 last. The counter counts 0..NT.
  - COEF_LD=0 while in LOAD holds the counter (pause allowed, no timeout).
  - On the edge capturing the (NT+1)-th word the FSM returns to IDLE. On the following edge the shadow bank is copied to the active bank and COEF_DONE pulses high for 1 cycle.
- Coefficient use and reload:
  - Products use the active bank at the stage-1 register.
  - Samples captured at or before the swap edge use the old bank; samples captured after it use the new bank.
  - The delay line is not flushed on a swap. COEF_LD and VIN are independent and may be active together.
- Reset mid-load discards the partial shadow contents. Reset mid-stream drops in-flight valids, so VOUT=0 on the next cycle.

Decomposition:
- Package fir_pkg:
  - ACC_W(NB,NT) width function.
  - Saturate-and-shift function.
  - FSM state enum {IDLE, LOAD}.
  - Lane slice helper.
- Sub-module fir_lane, instantiated L times:
  - Inputs: NT+1 sample taps and active coefficients.
  - Output: one saturated NB-bit result; contains the optional product register.
- The top level owns the delay line, coefficient banks, FSM and valid pipeline.

Test Plan:
All scenarios use NB=8, NT=10, L=3, PIPE=0 unless stated.
1. Reset: hold RST=1 for 2 cycles with VIN=1 and COEF_LD=1 -> DOUT=0, VOUT=0, COEF_DONE=0; no coefficient written.
2. Impulse:
   - Load b = -1,-2,-4,8,35,50,35,8,-4,-2,-1, then wait for COEF_DONE.
   - Feed x[0]=127 followed by zeros.
   - Required y[0..10] = -1,-2,-4,7,34,49,34,7,-4,-2,-1 spread across lanes; y[11..]=0.
   - VOUT is 1 cycle after each VIN sample edge; repeat with PIPE=1 for 2 cycles.
3. Saturation: all b=127.
   - Constant x=127 -> steady-state y=127 (raw value 1386).
   - Constant x=-128 -> y=-128 (raw value -1397).
4. VIN gaps: impulse stimulus of scenario 2 with random VIN=0 cycles inserted -> VOUT=0 and DOUT held in gaps; the valid output sequence is identical to scenario 2.
5. In-stream reload:
   - Stream continuously while loading b_0=64, all other taps 0, including a 3-cycle COEF_LD pause.
   - COEF_DONE pulses once, exactly 1 cycle after the 11th word.
   - Blocks captured after the swap give y=floor(x/2), e.g. x=-3 -> -2; earlier blocks match the old bank.
6. Reset mid-operation: assert RST during LOAD (word 5) and during streaming -> the next load restarts at index NT; active bank and delay line are zero; VOUT=0 on the following cycle.
